// File: rtl/sieve_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : sieve_stream_if
// Brief    : Flag-RAM port and prime output stream of the sieve engine.
// Revision : 1.0
// ============================================================================
interface sieve_stream_if #(
   parameter int AW = 8
);
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic          mem_wdata;
   logic          mem_rdata;
   logic          prime_valid;
   logic [AW-1:0] prime_data;
   logic          prime_ready;

   modport master (
      output mem_addr, mem_wr, mem_wdata, prime_valid, prime_data,
      input  mem_rdata, prime_ready
   );

   modport slave (
      input  mem_addr, mem_wr, mem_wdata, prime_valid, prime_data,
      output mem_rdata, prime_ready
   );
endinterface
`default_nettype wire

// File: rtl/sieve_stream.sv
`default_nettype none
// ============================================================================
// Module   : sieve_stream
// Brief    : Sieve of Eratosthenes over an external 1-bit flag RAM, primes
//            streamed out on a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module sieve_stream #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] limit,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] count,
   sieve_stream_if.master bus
);

   localparam logic [3:0] c_IDLE      = 4'd0;
   localparam logic [3:0] c_INIT      = 4'd1;
   localparam logic [3:0] c_OUTER_RD  = 4'd2;
   localparam logic [3:0] c_OUTER_CHK = 4'd3;
   localparam logic [3:0] c_CROSS     = 4'd4;
   localparam logic [3:0] c_SCAN_RD   = 4'd5;
   localparam logic [3:0] c_SCAN_CHK  = 4'd6;
   localparam logic [3:0] c_EMIT      = 4'd7;
   localparam logic [3:0] c_DONE      = 4'd8;

   logic [3:0]      r_state;
   logic [3:0]      w_state_nxt;
   logic [AW-1:0]   r_lim;
   logic [AW-1:0]   r_i;
   logic [AW:0]     r_j;
   logic [AW:0]     r_a;
   logic [AW-1:0]   r_count;
   logic            r_busy;
   logic            r_done;
   logic            r_prime_valid;
   logic [AW-1:0]   r_prime_data;

   // j, j+i and a carry one extra bit so lim = 2^AW-1 never wraps
   logic [2*AW-1:0] w_ii;
   logic [AW:0]     w_ji;
   logic            w_ii_gt;
   logic            w_ji_gt;
   logic            w_a_gt;
   logic            w_a_eq;
   logic            w_start_ok;

   assign w_ii       = {{AW{1'b0}}, r_i} * {{AW{1'b0}}, r_i};
   assign w_ji       = r_j + {1'b0, r_i};
   assign w_ii_gt    = w_ii > {{AW{1'b0}}, r_lim};
   assign w_ji_gt    = w_ji > {1'b0, r_lim};
   assign w_a_gt     = r_a > {1'b0, r_lim};
   assign w_a_eq     = r_a == {1'b0, r_lim};
   assign w_start_ok = start && ((r_state == c_IDLE) || (r_state == c_DONE));

   assign busy            = r_busy;
   assign done            = r_done;
   assign count           = r_count;
   assign bus.prime_valid = r_prime_valid;
   assign bus.prime_data  = r_prime_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE, c_DONE: if (w_start_ok) w_state_nxt = c_INIT;
         c_INIT:         if (w_a_eq) w_state_nxt = c_OUTER_RD;
         c_OUTER_RD:     w_state_nxt = w_ii_gt ? c_SCAN_RD : c_OUTER_CHK;
         c_OUTER_CHK:    w_state_nxt = bus.mem_rdata ? c_CROSS : c_OUTER_RD;
         c_CROSS:        if (w_ji_gt) w_state_nxt = c_OUTER_RD;
         c_SCAN_RD:      w_state_nxt = w_a_gt ? c_DONE : c_SCAN_CHK;
         c_SCAN_CHK:     w_state_nxt = bus.mem_rdata ? c_EMIT : c_SCAN_RD;
         c_EMIT:         if (bus.prime_ready) w_state_nxt = c_SCAN_RD;
         default:        w_state_nxt = c_IDLE;
      endcase
   end

   // RAM strobes decode from registered state only, never from inputs
   always_comb begin
      bus.mem_wr    = 1'b0;
      bus.mem_wdata = 1'b0;
      bus.mem_addr  = '0;
      case (r_state)
         c_INIT: begin
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = r_a[AW-1:0];
            bus.mem_wdata = (r_a >= (AW+1)'(2));
         end
         c_OUTER_RD: if (!w_ii_gt) bus.mem_addr = r_i;
         c_CROSS: begin
            bus.mem_wr   = 1'b1;
            bus.mem_addr = r_j[AW-1:0];
         end
         c_SCAN_RD: if (!w_a_gt) bus.mem_addr = r_a[AW-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lim         <= '0;
         r_i           <= '0;
         r_j           <= '0;
         r_a           <= '0;
         r_count       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_prime_valid <= 1'b0;
         r_prime_data  <= '0;
      end else begin
         case (r_state)
            c_IDLE, c_DONE: begin
               if (w_start_ok) begin
                  r_lim   <= limit;
                  r_a     <= '0;
                  r_count <= '0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            c_INIT: begin
               if (w_a_eq) r_i <= AW'(2);
               else        r_a <= r_a + (AW+1)'(1);
            end
            c_OUTER_RD: if (w_ii_gt) r_a <= (AW+1)'(2);
            c_OUTER_CHK: begin
               if (bus.mem_rdata) r_j <= w_ii[AW:0];
               else               r_i <= r_i + AW'(1);
            end
            c_CROSS: begin
               if (w_ji_gt) r_i <= r_i + AW'(1);
               else         r_j <= w_ji;
            end
            c_SCAN_RD: begin
               if (w_a_gt) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            c_SCAN_CHK: begin
               if (bus.mem_rdata) begin
                  r_prime_valid <= 1'b1;
                  r_prime_data  <= r_a[AW-1:0];
               end else begin
                  r_a <= r_a + (AW+1)'(1);
               end
            end
            c_EMIT: begin
               if (bus.prime_ready) begin
                  r_prime_valid <= 1'b0;
                  r_count       <= r_count + AW'(1);
                  r_a           <= r_a + (AW+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sieve_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sieve_stream
// Brief    : Directed self-checking bench for sieve_stream with a flag-RAM model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sieve_stream;
   localparam int AW = 8;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] limit = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] count;

   sieve_stream_if #(.AW(AW)) bus();

   sieve_stream #(.AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .limit (limit),
      .busy  (busy),
      .done  (done),
      .count (count),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // single-port RAM, read data one cycle after the address
   logic ram [0:2**AW-1];
   always @(posedge clk) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int primes_tbl [54] = '{
        2,   3,   5,   7,  11,  13,  17,  19,  23,  29,  31,  37,  41,  43,
       47,  53,  59,  61,  67,  71,  73,  79,  83,  89,  97, 101, 103, 107,
      109, 113, 127, 131, 137, 139, 149, 151, 157, 163, 167, 173, 179, 181,
      191, 193, 197, 199, 211, 223, 227, 229, 233, 239, 241, 251};

   int n_tests  = 0;
   int n_fail   = 0;
   int got[$];
   int bad_wr   = 0;
   int unstable = 0;
   int cur_lim  = 255;
   bit rnd_mode = 1'b0;
   bit p_stall  = 1'b0;
   logic [AW-1:0] p_data = '0;

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int n_primes(input int lim);
      int n = 0;
      for (int k = 0; k < 54; k++) if (primes_tbl[k] <= lim) n++;
      return n;
   endfunction

   initial begin
      bus.prime_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.prime_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   // transfer capture, write-range and back-pressure stability monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            p_stall = 1'b0;
         end else begin
            if (bus.mem_wr && int'(bus.mem_addr) > cur_lim) bad_wr++;
            if (p_stall && (!bus.prime_valid || bus.prime_data !== p_data)) unstable++;
            if (bus.prime_valid && bus.prime_ready) got.push_back(int'(bus.prime_data));
            p_stall = bus.prime_valid && !bus.prime_ready;
            p_data  = bus.prime_data;
         end
      end
   end

   task automatic do_start(input int lim);
      @(posedge clk);
      #1;
      got.delete();
      bad_wr   = 0;
      unstable = 0;
      cur_lim  = lim;
      limit    = AW'(lim);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   task automatic run_check(input string tag, input int lim);
      int n;
      for (int k = 0; k < 30000 && !done; k++) @(negedge clk);
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      n = n_primes(lim);
      chk({tag, "_nprimes"}, got.size(), n);
      chk({tag, "_count"}, int'(count), n);
      for (int k = 0; k < got.size() && k < n; k++)
         chk($sformatf("%s_p%0d", tag, k), got[k], primes_tbl[k]);
      chk({tag, "_last"}, (got.size() > 0) ? got[got.size()-1] : -1,
          (n > 0) ? primes_tbl[n-1] : -1);
      chk({tag, "_bad_wr"}, bad_wr, 0);
      chk({tag, "_unstable"}, unstable, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  int'(busy), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_wr",    int'(bus.mem_wr), 0);
      chk("rst_pv",    int'(bus.prime_valid), 0);
      rst = 1'b0;

      do_start(100);
      chk("start_busy",  int'(busy), 1);
      chk("start_wr",    int'(bus.mem_wr), 1);
      chk("start_addr",  int'(bus.mem_addr), 0);
      chk("start_wdata", int'(bus.mem_wdata), 0);
      run_check("l100", 100);

      rnd_mode = 1'b1;
      do_start(100);
      run_check("l100r", 100);
      rnd_mode = 1'b0;

      do_start(255);
      run_check("l255", 255);

      for (int l = 0; l <= 2; l++) begin
         do_start(l);
         run_check($sformatf("l%0d", l), l);
      end

      do_start(100);
      repeat (50) @(posedge clk);
      #1;
      chk("mid_busy", int'(busy), 1);
      limit = AW'(10);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      run_check("mid", 100);

      do_start(30);
      chk("restart_count", int'(count), 0);
      chk("restart_done",  int'(done), 0);
      run_check("l30", 30);

      do_start(50);
      begin
         bit hit = 1'b0;
         for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (bus.mem_wr && !bus.mem_wdata && int'(bus.mem_addr) >= 4) hit = 1'b1;
         end
         chk("cross_seen", int'(hit), 1);
      end
      #1;
      rst = 1'b1;
      #1;
      chk("arst_busy",  int'(busy), 0);
      chk("arst_done",  int'(done), 0);
      chk("arst_count", int'(count), 0);
      chk("arst_wr",    int'(bus.mem_wr), 0);
      chk("arst_addr",  int'(bus.mem_addr), 0);
      chk("arst_pv",    int'(bus.prime_valid), 0);
      chk("arst_pd",    int'(bus.prime_data), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_start(50);
      run_check("l50", 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sieve_stream.md
# sieve_stream

Parametrised Sieve of Eratosthenes engine that computes all primes up to a run-time limit using an external 1-bit flag memory and streams them out over a valid/ready handshake. It succeeds the fixed-limit, free-running sieve: address width is a parameter, the limit is sampled per run, runs start on request, crossing-off begins at i*i and stops once i*i > limit, and output honours back-pressure. It sits between a single-port flag RAM (owned by the parent) and any prime consumer.

## Interface

- AW, 8, address/number width; largest supported limit is 2^AW-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; accepted only when busy=0
- limit  in  AW  sieve upper bound, sampled on accepted start
- busy  out  1  high from accepted start until entry to DONE
- done  out  1  high in DONE; cleared by next accepted start
- mem_addr  out  AW  flag RAM address
- mem_wr  out  1  flag RAM write strobe
- mem_wdata  out  1  flag RAM write data (1 = candidate prime)
- mem_rdata  in  1  flag RAM read data, valid the cycle after the address is presented with mem_wr=0
- prime_valid  out  1  prime_data holds a prime
- prime_data  out  AW  prime value
- prime_ready  in  1  consumer accepts when high with prime_valid
- count  out  AW  primes accepted by consumer this run

## Operation

- Reset: all outputs 0, state IDLE; internal i, j, a, lim cleared. Reset asserted mid-run aborts immediately; no further mem writes; RAM contents are don't-care.
- IDLE: on start, lim<=limit, a<=0, count<=0, done<=0, busy<=1, go INIT.
- INIT: each cycle mem_wr=1, mem_addr=a, mem_wdata=(a>=2); after writing a==lim go OUTER_RD with i=2.
- OUTER_RD: if i*i > lim go SCAN_RD with a=2; else mem_wr=0, mem_addr=i, go OUTER_CHK.
- OUTER_CHK: if mem_rdata=1, j<=i*i, go CROSS; else i<=i+1, go OUTER_RD.
- CROSS: mem_wr=1, mem_addr=j, mem_wdata=0; if j+i > lim then i<=i+1, go OUTER_RD; else j<=j+i.
- SCAN_RD: if a > lim go DONE; else mem_wr=0, mem_addr=a, go SCAN_CHK.
- SCAN_CHK: if mem_rdata=1, prime_valid<=1, prime_data<=a, go EMIT; else a<=a+1, go SCAN_RD.
- EMIT: hold prime_valid and prime_data stable; on prime_ready: prime_valid<=0, count<=count+1, a<=a+1, go SCAN_RD.
- DONE: busy=0, done=1; start accepted as in IDLE (restart).
- Width rules: i*i computed in 2*AW bits; j, j+i, a held in AW+1 bits so lim=2^AW-1 never wraps or writes addresses outside 0..lim. mem_addr is the low AW bits.
- lim<2: INIT writes 0 to addresses 0..lim, outer loop exits at once (4>lim), scan finds nothing, DONE with count=0.
- start while busy=1: ignored, limit not resampled.
- mem_wr is 0 in every state except INIT and CROSS.

## Timing

- Accepted start -> first INIT write: next cycle.
- INIT: lim+1 cycles.
- Read cost: 2 cycles per flag (address cycle + check cycle).
- Per marked i: 2 cycles (read/check) + number of multiples from i*i to lim (one write per cycle).
- EMIT: prime_valid rises the cycle after SCAN_CHK; transfer in the cycle prime_valid & prime_ready; earliest next prime_valid 3 cycles later.
- done/busy update the cycle SCAN_RD sees a > lim.
- All outputs registered; no combinational path from prime_ready or mem_rdata to outputs.

## Test plan

- AW=8, limit=100, prime_ready tied 1 -> 25 primes 2,3,5,...,97 in order, count=25, done=1, busy=0; no write to address >100.
- limit=100, prime_ready random 30% duty -> identical sequence; prime_data never changes while prime_valid=1 and prime_ready=0.
- AW=8, limit=255 -> 54 primes, last 251; addresses written all <=255, no wrap-around writes to low addresses.
- limit=0, 1, 2 -> 0, 0, 1 prime(s) (2 only for limit=2); done asserted each time.
- start pulsed mid-run with limit=10 -> ignored, run completes for original limit; then start with limit=30 from DONE -> 10 primes ending 29, count reset to 0 first.
- rst asserted during CROSS -> all outputs 0 same cycle (async); after release, start limit=50 -> 15 primes, last 47.
